// File: rtl/lisnoc_pkg.sv
// Shared lisnoc definitions: flit type encodings, tail decode and packet buffer states.
package lisnoc_pkg;

  localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
  localparam logic [1:0] FLIT_HEADER  = 2'b01;
  localparam logic [1:0] FLIT_LAST    = 2'b10;
  localparam logic [1:0] FLIT_SINGLE  = 2'b11;

  typedef enum logic {
    STORE = 1'b0,
    CUT   = 1'b1
  } buf_state_t;

  function automatic logic flit_is_tail(input logic [1:0] flit_type);
    return (flit_type == FLIT_LAST) || (flit_type == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/lisnoc_fifo.sv
// In-order flit FIFO with occupancy counter; depth need not be a power of two.
module lisnoc_fifo #(
  parameter int width = 34,
  parameter int depth = 16,
  localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1,
  localparam int cnt_w = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [cnt_w-1:0] occupancy
);

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(depth - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  assign full     = (occupancy == cnt_w'(depth));
  assign empty    = (occupancy == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + cnt_w'(1);
        2'b01:   occupancy <= occupancy - cnt_w'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/lisnoc_packet_buffer.sv
// Store-and-forward packet buffer between a router local port and an endpoint;
// falls back to cut-through when a single packet fills the whole FIFO.
module lisnoc_packet_buffer
  import lisnoc_pkg::*;
#(
  parameter int noc_data_width = 32,
  parameter int noc_type_width = 2,
  parameter int fifo_depth     = 16,
  localparam int flit_width    = noc_data_width + noc_type_width,
  localparam int cnt_w         = $clog2(fifo_depth + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [flit_width-1:0] in_flit,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [flit_width-1:0] out_flit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [cnt_w-1:0]      packet_count,
  output logic                  oversize,
  output logic                  debug_state,
  output logic [cnt_w-1:0]      debug_occupancy
);

  // Handshake: a flit moves when valid & ready are both high at a rising edge;
  // valid never depends on ready, and in_ready never depends on out_ready.

  buf_state_t       state, state_next;
  logic [cnt_w-1:0] count_next;
  logic             partial_q, partial_next;
  logic             cut_tail_in_q, cut_tail_in_next;
  logic             oversize_next;
  logic             active_q;
  logic             fifo_full, fifo_empty;
  logic             in_fire, out_fire;
  logic             tail_in, tail_out;
  logic             inc, dec;

  lisnoc_fifo #(
    .width (flit_width),
    .depth (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_fire),
    .push_data (in_flit),
    .pop       (out_fire),
    .pop_data  (out_flit),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (debug_occupancy)
  );

  assign in_ready    = active_q & ~fifo_full;
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;
  assign tail_in     = flit_is_tail(in_flit[noc_data_width +: 2]);
  assign tail_out    = flit_is_tail(out_flit[noc_data_width +: 2]);
  assign debug_state = state;

  always_comb begin
    state_next       = state;
    partial_next     = partial_q;
    cut_tail_in_next = cut_tail_in_q;
    oversize_next    = oversize;
    out_valid        = 1'b0;
    dec              = 1'b0;
    // In CUT only the first tail to arrive closes the oversized packet; later
    // tails belong to new packets and must be counted or they would never drain.
    inc = in_fire & tail_in & ~((state == CUT) & ~cut_tail_in_q);
    case (state)
      STORE: begin
        out_valid = ~fifo_empty & ((packet_count != '0) | partial_q);
        dec       = out_fire & tail_out;
        if (out_fire) partial_next = ~tail_out;
        if (fifo_full && (packet_count == '0)) begin
          state_next       = CUT;
          oversize_next    = 1'b1;
          cut_tail_in_next = 1'b0;
        end
      end
      CUT: begin
        out_valid = ~fifo_empty;
        if (in_fire && tail_in) cut_tail_in_next = 1'b1;
        if (out_fire && tail_out) begin
          state_next   = STORE;
          partial_next = 1'b0;
        end
      end
      default: state_next = STORE;
    endcase
    case ({inc, dec})
      2'b10:   count_next = packet_count + cnt_w'(1);
      2'b01:   count_next = packet_count - cnt_w'(1);
      default: count_next = packet_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= STORE;
      packet_count  <= '0;
      partial_q     <= 1'b0;
      cut_tail_in_q <= 1'b0;
      oversize      <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state         <= state_next;
      packet_count  <= count_next;
      partial_q     <= partial_next;
      cut_tail_in_q <= cut_tail_in_next;
      oversize      <= oversize_next;
      active_q      <= 1'b1;
    end
  end

endmodule

// File: doc/lisnoc_packet_buffer.md
LISNOC_PACKET_BUFFER -- requirements
Module: lisnoc_packet_buffer

Interface
REQ-001 Parameter noc_data_width, default 32, flit payload width.
REQ-002 Parameter noc_type_width, default 2, flit type width; flit width = noc_data_width+noc_type_width, type in MSBs.
REQ-003 Parameter fifo_depth, default 16, flit storage entries; legal range 2..256, power of two not required.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in_flit  input  flit width  flit from router local port.
REQ-007 in_valid  input  1  in_flit valid.
REQ-008 in_ready  output  1  buffer accepts in_flit this cycle.
REQ-009 out_flit  output  flit width  flit toward message-passing endpoint noc_in.
REQ-010 out_valid  output  1  out_flit valid.
REQ-011 out_ready  input  1  endpoint accepts out_flit.
REQ-012 packet_count  output  clog2(fifo_depth+1)  number of complete packets held.
REQ-013 oversize  output  1  sticky flag: a packet exceeded fifo_depth flits.

Function
REQ-014 Flit types: 2'b00 payload, 2'b01 header, 2'b10 last, 2'b11 single; "tail" = last or single.
REQ-015 Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
REQ-016 in_ready = not full; independent of out_ready (no same-cycle pass-through into a full buffer).
REQ-017 Storage is in-order FIFO; a flit written in cycle N is visible on out_flit no earlier than N+1 (no bypass).
REQ-018 out_flit = head entry, driven combinationally from storage; undefined content permitted only while out_valid=0.
REQ-019 State machine, two states: STORE (reset state), CUT.
REQ-020 STORE: out_valid = (packet_count != 0) or (a packet is partially drained, i.e. a non-tail flit of it has already left).
REQ-021 packet_count increments on input tail transfer, decrements on output tail transfer; both in one cycle: unchanged.
REQ-022 STORE->CUT when FIFO full and packet_count == 0; oversize set same edge.
REQ-023 CUT: out_valid = not empty; input tail transfer while in CUT does not increment packet_count (packet is already being forwarded).
REQ-024 CUT->STORE on the output transfer of the tail flit of the oversized packet; packet_count unaffected by that tail.
REQ-025 Full and empty evaluated on occupancy counter 0..fifo_depth; pointers wrap modulo fifo_depth.
REQ-026 Flit type is not validated: a payload flit without preceding header is stored and forwarded unchanged.
REQ-027 oversize clears only on reset.

Reset
REQ-028 On rst low, immediately: FIFO empty, pointers 0, packet_count 0, state STORE, oversize 0, out_valid 0, in_ready 0 while rst low.
REQ-029 in_ready 1 from the first clock edge after rst deasserts; reset mid-packet discards all stored flits, no partial packet emitted.

Structure
REQ-030 Flit-type constants and the tail-decode helper live in the shared lisnoc package/include used by all lisnoc blocks.
REQ-031 Flit storage is one sub-module, lisnoc_fifo (flit FIFO with push/pop, full/empty, occupancy); packet accounting and state machine stay in the top.

Verification
REQ-032 Single flit 0x3_00000001 in, out_ready=1 -> out_valid rises exactly 1 cycle after input; packet_count 1 then 0.
REQ-033 4-flit packet (header, 2 payload, last) with out_ready=1 -> out_valid stays 0 until last flit stored, then 4 flits out consecutively, same order and values.
REQ-034 fifo_depth=16, 20-flit packet, out_ready=1 -> after 16 flits in_ready=0, oversize=1, state CUT, all 20 flits delivered in order, state returns to STORE.
REQ-035 Out_ready=0, three single flits then stall -> packet_count 3; release out_ready with simultaneous new single -> count stays 3 that cycle.
REQ-036 Fill 16 flits (four 4-flit packets), out_ready=0 -> in_ready=0, no flit lost; drain -> pointers wrap, next packet correct.
REQ-037 rst low mid-packet (2 of 4 flits stored) -> out_valid 0, packet_count 0 immediately; after release a new packet passes normally.
